// File: rtl/bfu_pkg.sv
// Shared types and fixed-point helpers for the pipelined radix-2 butterfly.
// Helpers work on a wide signed carrier so one function serves every stage width.
package bfu_pkg;

  localparam int unsigned WIDTH_DEF = 9;
  localparam int unsigned FRAC_DEF  = WIDTH_DEF - 1;

  typedef logic signed [63:0] wide_t;

  // Arithmetic right shift with optional round-half-up bias of 2^(sh-1).
  function automatic wide_t round_shift(input wide_t v, input int unsigned sh, input logic rnd);
    wide_t r;
    r = v;
    if (rnd && (sh != 0)) r = r + (wide_t'(1) <<< (sh - 1));
    return r >>> sh;
  endfunction

  function automatic logic in_range(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    return (v <= hi) && (v >= lo);
  endfunction

  // Saturate to w-bit signed range, or keep the low w bits sign-extended (wrap).
  function automatic wide_t sat_wrap(input wide_t v, input int unsigned w, input logic sat);
    wide_t hi;
    wide_t lo;
    wide_t r;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    r  = v;
    if (v > hi) begin
      r = sat ? hi : ((v <<< (64 - w)) >>> (64 - w));
    end else if (v < lo) begin
      r = sat ? lo : ((v <<< (64 - w)) >>> (64 - w));
    end
    return r;
  endfunction

endpackage

// File: rtl/bfu_cmult.sv
// Two-stage complex multiply b*w: S1 registers the four partial products,
// S2 combines, rounds, shifts by FRAC and clamps to WIDTH+1 bits.
module bfu_cmult
  import bfu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned FRAC  = WIDTH - 1,
  parameter int unsigned ROUND = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             in_valid,
  input  logic             v1,
  input  logic [WIDTH-1:0] br,
  input  logic [WIDTH-1:0] bi,
  input  logic [WIDTH-1:0] wr,
  input  logic [WIDTH-1:0] wi,
  output logic [WIDTH:0]   t_r,
  output logic [WIDTH:0]   t_i,
  output logic             t_ovf
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned TW = WIDTH + 1;

  logic signed [PW-1:0] prr_q, prr_d, pii_q, pii_d, pri_q, pri_d, pir_q, pir_d;
  logic [TW-1:0] tr_q, tr_d, ti_q, ti_d;
  logic          ovf_q, ovf_d;
  wide_t         pr_w, pi_w;

  always_comb begin
    prr_d = prr_q;
    pii_d = pii_q;
    pri_d = pri_q;
    pir_d = pir_q;
    if (adv && in_valid) begin
      prr_d = PW'($signed(br)) * PW'($signed(wr));
      pii_d = PW'($signed(bi)) * PW'($signed(wi));
      pri_d = PW'($signed(br)) * PW'($signed(wi));
      pir_d = PW'($signed(bi)) * PW'($signed(wr));
    end
  end

  // The clamp always saturates; the SAT choice applies only to the final results.
  always_comb begin
    pr_w  = round_shift(wide_t'(prr_q) - wide_t'(pii_q), FRAC, ROUND != 0);
    pi_w  = round_shift(wide_t'(pri_q) + wide_t'(pir_q), FRAC, ROUND != 0);
    tr_d  = tr_q;
    ti_d  = ti_q;
    ovf_d = ovf_q;
    if (adv && v1) begin
      tr_d  = TW'(sat_wrap(pr_w, TW, 1'b1));
      ti_d  = TW'(sat_wrap(pi_w, TW, 1'b1));
      ovf_d = !in_range(pr_w, TW) || !in_range(pi_w, TW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prr_q <= '0;
      pii_q <= '0;
      pri_q <= '0;
      pir_q <= '0;
      tr_q  <= '0;
      ti_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      prr_q <= prr_d;
      pii_q <= pii_d;
      pri_q <= pri_d;
      pir_q <= pir_d;
      tr_q  <= tr_d;
      ti_q  <= ti_d;
      ovf_q <= ovf_d;
    end
  end

  assign t_r   = tr_q;
  assign t_i   = ti_q;
  assign t_ovf = ovf_q;

endmodule

// File: rtl/bfu_pipe.sv
// Pipelined radix-2 DIT butterfly op1 = a + b*w, op2 = a - b*w with a single
// global advance, operand-isolated data registers and sticky overflow.
module bfu_pipe
  import bfu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned FRAC  = WIDTH - 1,
  parameter int unsigned ROUND = 0,
  parameter int unsigned SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_ar,
  input  logic [WIDTH-1:0] in_ai,
  input  logic [WIDTH-1:0] in_br,
  input  logic [WIDTH-1:0] in_bi,
  input  logic [WIDTH-1:0] in_wr,
  input  logic [WIDTH-1:0] in_wi,
  input  logic             in_scale,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op1r,
  output logic [WIDTH-1:0] op1i,
  output logic [WIDTH-1:0] op2r,
  output logic [WIDTH-1:0] op2i,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  logic             adv;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [WIDTH-1:0] a1r_q, a1r_d, a1i_q, a1i_d, a2r_q, a2r_d, a2i_q, a2i_d;
  logic             sc1_q, sc1_d, sc2_q, sc2_d;
  logic [WIDTH-1:0] op_q [4];
  logic [WIDTH-1:0] op_d [4];
  logic             ovf_q, ovf_d, sticky_q, sticky_d;
  logic [WIDTH:0]   t_r, t_i;
  logic             t_ovf;
  wide_t            s [4];
  logic             s_ovf;

  assign adv      = !v3_q || out_ready;
  assign in_ready = adv;

  bfu_cmult #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ROUND (ROUND)
  ) u_cmult (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (adv),
    .in_valid (in_valid),
    .v1       (v1_q),
    .br       (in_br),
    .bi       (in_bi),
    .wr       (in_wr),
    .wi       (in_wi),
    .t_r      (t_r),
    .t_i      (t_i),
    .t_ovf    (t_ovf)
  );

  always_comb begin
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    a1r_d    = a1r_q;
    a1i_d    = a1i_q;
    sc1_d    = sc1_q;
    a2r_d    = a2r_q;
    a2i_d    = a2i_q;
    sc2_d    = sc2_q;
    sticky_d = sticky_q;
    if (adv) begin
      v1_d = in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
    end
    if (adv && in_valid) begin
      a1r_d = in_ar;
      a1i_d = in_ai;
      sc1_d = in_scale;
    end
    if (adv && v1_q) begin
      a2r_d = a1r_q;
      a2i_d = a1i_q;
      sc2_d = sc1_q;
    end
    // A flagged transfer overrides a simultaneous clear.
    if (ovf_clr) sticky_d = 1'b0;
    if (v3_q && out_ready && ovf_q) sticky_d = 1'b1;
  end

  always_comb begin
    s[0]  = wide_t'($signed(a2r_q)) + wide_t'($signed(t_r));
    s[1]  = wide_t'($signed(a2i_q)) + wide_t'($signed(t_i));
    s[2]  = wide_t'($signed(a2r_q)) - wide_t'($signed(t_r));
    s[3]  = wide_t'($signed(a2i_q)) - wide_t'($signed(t_i));
    s_ovf = t_ovf;
    op_d  = op_q;
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sc2_q) s[i] = round_shift(s[i], 1, ROUND != 0);
      if (!in_range(s[i], WIDTH)) s_ovf = 1'b1;
    end
    if (adv && v2_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        op_d[i] = WIDTH'(sat_wrap(s[i], WIDTH, SAT != 0));
      end
      ovf_d = s_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      a1r_q    <= '0;
      a1i_q    <= '0;
      sc1_q    <= 1'b0;
      a2r_q    <= '0;
      a2i_q    <= '0;
      sc2_q    <= 1'b0;
      op_q     <= '{default: '0};
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      a1r_q    <= a1r_d;
      a1i_q    <= a1i_d;
      sc1_q    <= sc1_d;
      a2r_q    <= a2r_d;
      a2i_q    <= a2i_d;
      sc2_q    <= sc2_d;
      op_q     <= op_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = v3_q;
  assign op1r       = op_q[0];
  assign op1i       = op_q[1];
  assign op2r       = op_q[2];
  assign op2i       = op_q[3];
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_bfu_pipe.sv
// Scoreboard bench for bfu_pipe: three instances (default, ROUND=1, SAT=0)
// share one stimulus stream; a monitor checks each output beat against a queue.
module tb_bfu_pipe;

  localparam int W = 9;

  typedef struct packed {
    int o1r;
    int o1i;
    int o2r;
    int o2i;
    bit ovf;
  } res_t;

  typedef struct {
    int         ar, ai, br, bi, wr, wi;
    bit         sc;
    res_t [2:0] e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         ovf_clr = 1'b0;
  logic         in_scale = 1'b0;
  logic [W-1:0] in_ar = '0, in_ai = '0, in_br = '0, in_bi = '0, in_wr = '0, in_wi = '0;
  logic         in_ready [3];
  logic         out_valid [3];
  logic         out_ovf [3];
  logic         ovf_sticky [3];
  logic [W-1:0] op1r [3];
  logic [W-1:0] op1i [3];
  logic [W-1:0] op2r [3];
  logic [W-1:0] op2i [3];

  int   checks = 0;
  int   failures = 0;
  vec_t stim_q[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  bfu_pipe #(.WIDTH(W), .ROUND(0), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi), .in_wr(in_wr), .in_wi(in_wi),
    .in_scale(in_scale), .out_valid(out_valid[0]), .out_ready(out_ready),
    .op1r(op1r[0]), .op1i(op1i[0]), .op2r(op2r[0]), .op2i(op2i[0]),
    .out_ovf(out_ovf[0]), .ovf_sticky(ovf_sticky[0]), .ovf_clr(ovf_clr)
  );

  bfu_pipe #(.WIDTH(W), .ROUND(1), .SAT(1)) dut_rnd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi), .in_wr(in_wr), .in_wi(in_wi),
    .in_scale(in_scale), .out_valid(out_valid[1]), .out_ready(out_ready),
    .op1r(op1r[1]), .op1i(op1i[1]), .op2r(op2r[1]), .op2i(op2i[1]),
    .out_ovf(out_ovf[1]), .ovf_sticky(ovf_sticky[1]), .ovf_clr(ovf_clr)
  );

  bfu_pipe #(.WIDTH(W), .ROUND(0), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi), .in_wr(in_wr), .in_wi(in_wi),
    .in_scale(in_scale), .out_valid(out_valid[2]), .out_ready(out_ready),
    .op1r(op1r[2]), .op1i(op1i[2]), .op2r(op2r[2]), .op2i(op2i[2]),
    .out_ovf(out_ovf[2]), .ovf_sticky(ovf_sticky[2]), .ovf_clr(ovf_clr)
  );

  function automatic res_t rs(input int o1r, input int o1i, input int o2r, input int o2i, input bit ovf);
    res_t r;
    r.o1r = o1r; r.o1i = o1i; r.o2r = o2r; r.o2i = o2i; r.ovf = ovf;
    return r;
  endfunction

  function automatic vec_t mk(input int ar, input int ai, input int br, input int bi,
                              input int wr, input int wi, input bit sc,
                              input res_t d, input res_t r, input res_t w);
    vec_t v;
    v.ar = ar; v.ai = ai; v.br = br; v.bi = bi; v.wr = wr; v.wi = wi; v.sc = sc;
    v.e[0] = d; v.e[1] = r; v.e[2] = w;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    in_ar = W'(v.ar); in_ai = W'(v.ai);
    in_br = W'(v.br); in_bi = W'(v.bi);
    in_wr = W'(v.wr); in_wi = W'(v.wi);
    in_scale = v.sc;
  endtask

  // Streams stim_q with out_ready low for cycles [stall_at, stall_at+stall_len).
  task automatic run(input int stall_at, input int stall_len);
    int cyc;
    bit fire;
    cyc = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < 200) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (stim_q.size() > 0) begin
        drive(stim_q[0]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && out_valid[0]) begin
        for (int k = 0; k < 3; k++) chk($sformatf("in_ready_stall[%0d]", k), int'(in_ready[k]), 0);
      end
      fire = in_valid && in_ready[0];
      @(posedge clk);
      if (fire) exp_q.push_back(stim_q.pop_front());
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 200) begin
      checks++;
      failures++;
      $display("FAIL run_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic one_beat_latency(input vec_t v);
    int n;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    exp_q.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 3);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops and compares on every transfer; checks hold while stalled.
  initial begin : monitor
    vec_t v;
    bit   stalled;
    int   hold [4];
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        chk("stall_valid", int'(out_valid[0]), 1);
        chk("stall_op1r", int'($signed(op1r[0])), hold[0]);
        chk("stall_op1i", int'($signed(op1i[0])), hold[1]);
        chk("stall_op2r", int'($signed(op2r[0])), hold[2]);
        chk("stall_op2i", int'($signed(op2i[0])), hold[3]);
      end
      stalled = out_valid[0] && !out_ready;
      if (stalled) begin
        hold[0] = int'($signed(op1r[0]));
        hold[1] = int'($signed(op1i[0]));
        hold[2] = int'($signed(op2r[0]));
        hold[3] = int'($signed(op2i[0]));
      end
      if (out_valid[0] && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got op1r=%0d expected no beat", $signed(op1r[0]));
        end else begin
          v = exp_q.pop_front();
          for (int k = 0; k < 3; k++) begin
            chk($sformatf("valid[%0d]", k), int'(out_valid[k]), 1);
            chk($sformatf("op1r[%0d]", k), int'($signed(op1r[k])), v.e[k].o1r);
            chk($sformatf("op1i[%0d]", k), int'($signed(op1i[k])), v.e[k].o1i);
            chk($sformatf("op2r[%0d]", k), int'($signed(op2r[k])), v.e[k].o2r);
            chk($sformatf("op2i[%0d]", k), int'($signed(op2i[k])), v.e[k].o2i);
            chk($sformatf("ovf[%0d]", k), int'(out_ovf[k]), int'(v.e[k].ovf));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t v1, v2, v3, v4, v5;
    v1 = mk(64, 0, 64, 0, 255, 0, 1'b0,
            rs(127, 0, 1, 0, 1'b0), rs(128, 0, 0, 0, 1'b0), rs(127, 0, 1, 0, 1'b0));
    v2 = mk(10, 20, 100, 50, 0, -256, 1'b0,
            rs(60, -80, -40, 120, 1'b0), rs(60, -80, -40, 120, 1'b0), rs(60, -80, -40, 120, 1'b0));
    v3 = mk(200, 0, 200, 0, 255, 0, 1'b0,
            rs(255, 0, 1, 0, 1'b1), rs(255, 0, 1, 0, 1'b1), rs(-113, 0, 1, 0, 1'b1));
    v4 = mk(200, 0, 200, 0, 255, 0, 1'b1,
            rs(199, 0, 0, 0, 1'b0), rs(200, 0, 1, 0, 1'b0), rs(199, 0, 0, 0, 1'b0));
    v5 = mk(0, 0, -256, -256, -256, -256, 1'b0,
            rs(0, 255, 0, -256, 1'b1), rs(0, 255, 0, -256, 1'b1), rs(0, -1, 0, 1, 1'b1));

    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid[0]), 0);
    chk("rst_in_ready", int'(in_ready[0]), 1);
    chk("rst_op1r", int'(op1r[0]), 0);
    chk("rst_ovf", int'(out_ovf[0]), 0);
    chk("rst_sticky", int'(ovf_sticky[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    one_beat_latency(v1);
    stim_q.push_back(v2);
    stim_q.push_back(v4);
    run(1000, 0);

    stim_q.push_back(v3);
    run(1000, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("sticky_set[%0d]", k), int'(ovf_sticky[k]), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("sticky_clr", int'(ovf_sticky[0]), 0);

    stim_q.push_back(v5);
    run(1000, 0);
    @(negedge clk);
    ovf_clr = 1'b1;
    stim_q.push_back(v3);
    run(1000, 0);
    @(negedge clk);
    chk("sticky_set_wins", int'(ovf_sticky[0]), 1);
    @(negedge clk);
    chk("sticky_clr_next", int'(ovf_sticky[0]), 0);
    ovf_clr = 1'b0;

    for (int i = 1; i <= 8; i++) begin
      stim_q.push_back(mk(5 * i, -3 * i, 2 * i, i + 10, 0, -256, 1'b0,
                          rs(6 * i + 10, -5 * i, 4 * i - 10, -i, 1'b0),
                          rs(6 * i + 10, -5 * i, 4 * i - 10, -i, 1'b0),
                          rs(6 * i + 10, -5 * i, 4 * i - 10, -i, 1'b0)));
    end
    run(4, 3);

    @(negedge clk);
    drive(v2);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid[0]), 0);
    chk("midrst_op1r", int'(op1r[0]), 0);
    chk("midrst_op2i", int'(op2i[0]), 0);
    chk("midrst_in_ready", int'(in_ready[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_spurious_valid", int'(out_valid[0]), 0);
    end
    one_beat_latency(v4);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
